// File: rtl/vga_panel_compositor_if.sv
// Image RAM read bus shared by the compositor and the per-panel RAMs.
// The compositor drives the address and the one-hot read enable; every
// panel RAM returns its 24-bit RGB word in its own slice of mem_rdata.
interface vga_panel_compositor_if #(
  parameter int NUM_PANELS = 2,
  parameter int ADDR_W     = 16
);
  logic [ADDR_W-1:0]        mem_addr;
  logic [NUM_PANELS-1:0]    mem_rd_en;
  logic [NUM_PANELS*24-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rdata
  );
endinterface

// File: rtl/vga_panel_compositor.sv
// Pipelined panel compositor for the VGA output path.
// Maps a scan coordinate onto NUM_PANELS horizontally tiled image panels,
// issues one shared read address with a one-hot read enable, and realigns
// the returned RGB data with a tag delay line matched to the RAM latency.
// Latency is MEM_LAT+2 clocks, one pixel per clock, no bubbles.
module vga_panel_compositor #(
  parameter int NUM_PANELS = 2,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int GAP        = 10,
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int MEM_LAT    = 1,
  parameter int COORD_W    = 10,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_en,
  input  logic [COORD_W-1:0]    next_x,
  input  logic [COORD_W-1:0]    next_y,
  input  logic [NUM_PANELS-1:0] panel_en,
  input  logic [NUM_PANELS-1:0] mirror_x,
  input  logic [23:0]           bg_color,
  vga_panel_compositor_if.master mem,
  output logic [23:0]           pixel_color,
  output logic [2:0]            pixel_panel,
  output logic                  pixel_in_panel,
  output logic                  pixel_valid
);

  // Tag stages from E1 up to E(MEM_LAT+1); the output register is E(MEM_LAT+2).
  localparam int DL    = MEM_LAT + 1;
  // Tag layout: {valid, hit, panel[2:0], bg[23:0]}
  localparam int TAG_W = 29;

  logic                  s0_valid;
  logic [COORD_W-1:0]    s0_x;
  logic [COORD_W-1:0]    s0_y;
  logic [NUM_PANELS-1:0] s0_en;
  logic [NUM_PANELS-1:0] s0_mirror;
  logic [23:0]           s0_bg;

  logic [NUM_PANELS-1:0] panel_hit;
  logic [ADDR_W-1:0]     panel_addr [NUM_PANELS];
  logic                  hit_any;
  logic [2:0]            hit_idx;
  logic [ADDR_W-1:0]     addr_sel;

  logic [TAG_W-1:0]      dl_tag [1:DL];
  logic [TAG_W-1:0]      tail;
  logic [23:0]           rdata_slice [8];

  // Stage 0: sample coordinate and configuration together so mid-line
  // configuration changes only affect pixels sampled afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid  <= 1'b0;
      s0_x      <= '0;
      s0_y      <= '0;
      s0_en     <= '0;
      s0_mirror <= '0;
      s0_bg     <= '0;
    end else begin
      s0_valid  <= pix_en;
      s0_x      <= next_x;
      s0_y      <= next_y;
      s0_en     <= panel_en;
      s0_mirror <= mirror_x;
      s0_bg     <= bg_color;
    end
  end

  // Per-panel window test and address. Comparisons are done on full-width
  // integers so coordinates never wrap around a panel boundary.
  generate
    for (genvar gi = 0; gi < NUM_PANELS; gi++) begin : g_panel
      localparam int XP = X0 + gi * (IMG_W + GAP);
      int x_val;
      int y_val;
      int col_off;
      int col;
      assign x_val   = int'(s0_x);
      assign y_val   = int'(s0_y);
      assign col_off = x_val - XP;
      assign col     = s0_mirror[gi] ? (IMG_W - 1 - col_off) : col_off;
      assign panel_hit[gi] = s0_valid && s0_en[gi] &&
                             (x_val >= XP) && (x_val < XP + IMG_W) &&
                             (y_val >= Y0) && (y_val < Y0 + IMG_H);
      assign panel_addr[gi] = ADDR_W'((y_val - Y0) * IMG_W + col);
    end
  endgenerate

  // Pick the (at most one) hitting panel; a miss yields address 0.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    addr_sel = '0;
    for (int p = 0; p < NUM_PANELS; p++) begin
      if (panel_hit[p]) begin
        hit_any  = 1'b1;
        hit_idx  = 3'(p);
        addr_sel = panel_addr[p];
      end
    end
  end

  // E1 registers the RAM request and shifts the tag line alongside the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem.mem_addr  <= '0;
      mem.mem_rd_en <= '0;
      for (int k = 1; k <= DL; k++) begin
        dl_tag[k] <= '0;
      end
    end else begin
      mem.mem_addr  <= addr_sel;
      mem.mem_rd_en <= panel_hit;
      dl_tag[1]     <= {s0_valid, hit_any, hit_idx, s0_bg};
      for (int k = 2; k <= DL; k++) begin
        dl_tag[k] <= dl_tag[k-1];
      end
    end
  end

  assign tail = dl_tag[DL];

  // Split the RAM data bus into one slot per possible panel index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_slice
      if (gi < NUM_PANELS) begin : g_used
        assign rdata_slice[gi] = mem.mem_rdata[gi*24 +: 24];
      end else begin : g_unused
        assign rdata_slice[gi] = '0;
      end
    end
  endgenerate

  // Output stage: panel data on a hit, carried background on a miss,
  // everything zero for an invalid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_color    <= '0;
      pixel_panel    <= '0;
      pixel_in_panel <= 1'b0;
      pixel_valid    <= 1'b0;
    end else if (tail[28]) begin
      pixel_valid <= 1'b1;
      if (tail[27]) begin
        pixel_color    <= rdata_slice[tail[26:24]];
        pixel_panel    <= tail[26:24];
        pixel_in_panel <= 1'b1;
      end else begin
        pixel_color    <= tail[23:0];
        pixel_panel    <= '0;
        pixel_in_panel <= 1'b0;
      end
    end else begin
      pixel_color    <= '0;
      pixel_panel    <= '0;
      pixel_in_panel <= 1'b0;
      pixel_valid    <= 1'b0;
    end
  end

endmodule

// File: doc/vga_panel_compositor.md
Name: vga_panel_compositor

Overview:
- Pipelined, parametrised successor to the two-image coordinate interpreter in the VGA output path.
- Maps the scan coordinate (next_x, next_y) onto NUM_PANELS identical image panels laid out horizontally with a fixed gap.
- Issues a read address plus a one-hot panel read enable to the per-panel synchronous image RAMs.
- Realigns the returned RGB data with a delay line matched to RAM latency, and emits colour, panel id and valid to the VGA driver.

Parameters:
- NUM_PANELS, 2, number of image panels (1..8).
- IMG_W, 256, panel width in pixels.
- IMG_H, 256, panel height in pixels.
- GAP, 10, horizontal blank pixels between adjacent panels.
- X0, 0, x of left edge of panel 0.
- Y0, 0, y of top edge of all panels.
- MEM_LAT, 1, image RAM read latency in clocks (>=1).
- COORD_W, 10, coordinate width.
- ADDR_W, 16, RAM address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- pix_en  in  1  coordinate valid strobe.
- next_x  in  COORD_W  scan x.
- next_y  in  COORD_W  scan y.
- panel_en  in  NUM_PANELS  per-panel display enable.
- mirror_x  in  NUM_PANELS  per-panel horizontal flip.
- bg_color  in  24  colour outside panels.
- mem_addr  out  ADDR_W  RAM read address, shared by all panels.
- mem_rd_en  out  NUM_PANELS  one-hot read enable.
- mem_rdata  in  NUM_PANELS*24  RAM data; panel p occupies bits [24p+23:24p], RGB 8:8:8.
- pixel_color  out  24  output RGB.
- pixel_panel  out  3  panel index of the output pixel.
- pixel_in_panel  out  1  output pixel lies inside an enabled panel.
- pixel_valid  out  1  output pixel valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0. All pipeline stages are cleared, so in-flight pixels are discarded. The first valid output appears no earlier than MEM_LAT+2 cycles after rst deasserts with pix_en high.
- Pipeline: free-running; advances every clk. pix_en only tags the entry as valid.
- Stage 0, sampling edge E0:
  - Panel p spans x in [Xp, Xp+IMG_W), where Xp = X0 + p*(IMG_W+GAP).
  - All panels span y in [Y0, Y0+IMG_H).
  - Compare in COORD_W+1 bits; no wrap-around.
  - Hit is (x,y) inside panel p AND panel_en[p]. At most one panel can hit.
- Address:
  - col = x - Xp, or IMG_W-1-(x-Xp) when mirror_x[p] is set.
  - row = y - Y0.
  - addr = row*IMG_W + col, truncated to ADDR_W.
- Miss handling: on a miss, or when pix_en=0, mem_addr=0 and mem_rd_en=0.
- Edge E1: mem_addr and mem_rd_en are registered outputs.
- Delay line: carries {valid, hit, panel index} MEM_LAT+1 stages.
- Edge E(MEM_LAT+2):
  - Hit: pixel_color = mem_rdata slice of the tagged panel, pixel_in_panel=1.
  - Miss: pixel_color = bg_color sampled at E0 (bg_color is carried down the delay line), pixel_in_panel=0, pixel_panel=0.
  - pixel_valid = the delayed pix_en.
- Latency: MEM_LAT+2 cycles from sample to output (3 at defaults).
- Throughput: one pixel per clock, with no bubbles.
- Configuration inputs: panel_en, mirror_x and bg_color are sampled with the coordinate. Changing them mid-line affects only pixels sampled after the change.
- Invalid entries: when pixel_valid=0, pixel_color is held at 0.
- Edge pixels: the last pixel of a panel (x = Xp+IMG_W-1) hits. The first gap pixel (x = Xp+IMG_W) misses.

Test Plan:
- Reset: hold rst 3 cycles with pix_en=1 -> all outputs 0 during reset. Release rst at (5,2) -> pixel_valid=1 exactly 3 cycles later.
- Panel 0, defaults, panel_en=2'b11: pix_en=1, (x=5,y=2) -> at E1 mem_addr=517, mem_rd_en=2'b01. RAM0 returns 0xAABBCC -> at E3 pixel_color=0xAABBCC, pixel_panel=0, pixel_in_panel=1.
- Panel 1 edges:
  - (266,1) -> mem_addr=256, mem_rd_en=2'b10.
  - (521,255) -> mem_addr=65535, rd_en=2'b10.
  - (522,0) -> rd_en=2'b00, pixel_color=bg_color.
- Gap and disable:
  - bg_color=0x123456, (260,10) -> rd_en=0, pixel_color=0x123456, pixel_in_panel=0.
  - panel_en=2'b01, (300,10) -> same background response.
  - (0,256) -> background.
- Mirror: mirror_x=2'b10 -> (266,0) gives mem_addr=255, and (521,3) gives mem_addr=768. Panel 0 is unaffected: (0,0) gives addr 0.
- Streaming and reset mid-stream: x=254..268 on consecutive cycles at y=0 -> outputs in order, one per cycle: hits on panel 0 (x=254,255), then 10 background pixels, then panel 1 (x=266..268). Assert rst at the 5th cycle -> pixel_valid=0 from the next edge, and no stale pixels after release.
